// File: rtl/zx_mem_pkg.sv
// Shared types and slot constants for the SDRAM time-slot arbiter.
package zx_mem_pkg;

    typedef enum logic [1:0] {NONE, VID, CPU, DMA} owner_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    localparam logic [3:0] SLOT_VID   = 4'd0;
    localparam logic [3:0] SLOT_SHR   = 4'd8;
    localparam logic [3:0] TO_VID     = 4'd7;
    localparam logic [3:0] TO_SHR     = 4'd15;
    localparam logic [1:0] DMA_STARVE = 2'd3;

    // The CPU never sees the video slot; a starved DMA pre-empts the CPU in the shared slot.
    function automatic owner_t pick_winner(input logic shared, input logic vid_req,
                                           input logic cpu_req, input logic dma_req,
                                           input logic starved);
        owner_t w;
        w = NONE;
        if (!shared) begin
            if (vid_req)      w = VID;
            else if (dma_req) w = DMA;
        end else begin
            if (dma_req && starved) w = DMA;
            else if (cpu_req)       w = CPU;
            else if (dma_req)       w = DMA;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_arbiter_slot_phase.sv
// 16-clock frame phase counter, realigned by the 3.5 MHz sync strobe.
module slot_phase
    import zx_mem_pkg::*;
(
    input  logic clock,
    input  logic power,
    input  logic sync,
    output logic slot_start,
    output logic slot_kind,
    output logic slot_end
);

    logic [3:0] r_ph;

    always_ff @(posedge clock or negedge power) begin
        if (!power)    r_ph <= 4'd0;
        else if (sync) r_ph <= 4'd0;
        else           r_ph <= r_ph + 4'd1;
    end

    assign slot_start = (r_ph == SLOT_VID) || (r_ph == SLOT_SHR);
    assign slot_kind  = r_ph[3];
    assign slot_end   = (r_ph == TO_VID) || (r_ph == TO_SHR);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM port between video, CPU and DMA: one command per 8-clock slot,
// video slot in phases 0-7, CPU/DMA shared slot in phases 8-15.
module sdram_arbiter
    import zx_mem_pkg::*;
(
    input  logic        clock,
    input  logic        power,
    input  logic        sync,
    input  logic        vid_req,
    input  logic [23:0] vid_a,
    output logic [7:0]  vid_q,
    output logic        vid_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [23:0] dma_a,
    input  logic [7:0]  dma_d,
    output logic [7:0]  dma_q,
    output logic        dma_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_a,
    output logic [7:0]  mem_d,
    input  logic        mem_ack,
    input  logic [7:0]  mem_q,
    output logic        err
);

    logic       w_slot_start, w_slot_kind, w_slot_end;
    logic       w_issue, w_done, w_timeout;
    owner_t     w_winner, r_owner;
    arb_state_t r_state, w_state_nxt;
    logic [1:0] r_dma_wait;
    logic        r_mem_req, r_mem_we, r_err;
    logic [23:0] r_mem_a;
    logic [7:0]  r_mem_d, r_vid_q, r_cpu_q, r_dma_q;
    logic        r_vid_ack, r_cpu_ack, r_dma_ack;

    slot_phase u_phase (
        .clock      (clock),
        .power      (power),
        .sync       (sync),
        .slot_start (w_slot_start),
        .slot_kind  (w_slot_kind),
        .slot_end   (w_slot_end)
    );

    always_comb begin
        w_winner = pick_winner(w_slot_kind, vid_req, cpu_req, dma_req,
                               r_dma_wait == DMA_STARVE);
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Ack beats timeout when both land on the slot's last phase.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: if (w_slot_start && w_winner != NONE) begin
                w_issue     = 1'b1;
                w_state_nxt = ISSUE;
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: if (mem_ack) begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end else if (w_slot_end) begin
                w_timeout   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_owner    <= NONE;
            r_dma_wait <= 2'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_a    <= 24'd0;
            r_mem_d    <= 8'd0;
            r_vid_q    <= 8'd0;
            r_cpu_q    <= 8'd0;
            r_dma_q    <= 8'd0;
            r_vid_ack  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_req <= w_issue;
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            if (w_issue) begin
                r_owner <= w_winner;
                case (w_winner)
                    VID: begin r_mem_we <= 1'b0;   r_mem_a <= vid_a; r_mem_d <= 8'd0;  end
                    CPU: begin r_mem_we <= cpu_we; r_mem_a <= cpu_a; r_mem_d <= cpu_d; end
                    DMA: begin r_mem_we <= dma_we; r_mem_a <= dma_a; r_mem_d <= dma_d; end
                    default: ;
                endcase
                // Starvation count only tracks shared-slot outcomes.
                if (w_slot_kind) begin
                    if (w_winner == DMA) r_dma_wait <= 2'd0;
                    else if (dma_req)    r_dma_wait <= r_dma_wait + 2'd1;
                end
            end
            if (w_done) begin
                case (r_owner)
                    VID: begin r_vid_q <= mem_q; r_vid_ack <= 1'b1; end
                    CPU: begin r_cpu_q <= mem_q; r_cpu_ack <= 1'b1; end
                    DMA: begin r_dma_q <= mem_q; r_dma_ack <= 1'b1; end
                    default: ;
                endcase
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign mem_req = r_mem_req;
    assign mem_we  = r_mem_we;
    assign mem_a   = r_mem_a;
    assign mem_d   = r_mem_d;
    assign vid_q   = r_vid_q;
    assign cpu_q   = r_cpu_q;
    assign dma_q   = r_dma_q;
    assign vid_ack = r_vid_ack;
    assign cpu_ack = r_cpu_ack;
    assign dma_ack = r_dma_ack;
    assign err     = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_sdram_arbiter;

    logic        clock = 1'b0, power = 1'b0, sync = 1'b0;
    logic        vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
    logic        cpu_we = 1'b0, dma_we = 1'b0;
    logic [23:0] vid_a = '0, cpu_a = '0, dma_a = '0;
    logic [7:0]  cpu_d = '0, dma_d = '0;
    logic [7:0]  vid_q, cpu_q, dma_q;
    logic        vid_ack, cpu_ack, dma_ack;
    logic        mem_req, mem_we, err;
    logic [23:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_q = '0;

    always #5 clock = ~clock;

    sdram_arbiter dut (
        .clock(clock), .power(power), .sync(sync),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_d(dma_d),
        .dma_q(dma_q), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
        .mem_ack(mem_ack), .mem_q(mem_q), .err(err)
    );

    int errors = 0, checks = 0;

    // Reference model: one outstanding transaction with an age in clocks since its mem_req.
    typedef struct {int owner; logic we; logic [23:0] a; logic [7:0] d; int age;} txn_t;
    txn_t        cur;
    bit          busy;
    int          m_ph, m_dma_wait;
    logic        e_mem_req, e_mem_we, e_vack, e_cack, e_dack, e_err;
    logic [23:0] e_mem_a;
    logic [7:0]  e_mem_d, e_vq, e_cq, e_dq;

    bit          en_v, en_c, en_d, fixed, aligned = 1, rnd_sync, spurious, rnd_q;
    int          delay, sync_once = -1, ack_cd = 0;
    logic [7:0]  fix_q;
    logic        dummy_we;
    logic [7:0]  dummy_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; m_ph = 0; m_dma_wait = 0;
        {e_mem_req, e_mem_we, e_vack, e_cack, e_dack, e_err} = '0;
        e_mem_a = '0; e_mem_d = '0; e_vq = '0; e_cq = '0; e_dq = '0;
    endtask

    function automatic int pick();
        if (m_ph == 0) return vid_req ? 1 : (dma_req ? 3 : 0);
        if (dma_req && m_dma_wait >= 3) return 3;
        if (cpu_req) return 2;
        return dma_req ? 3 : 0;
    endfunction

    task automatic m_edge();
        int w;
        e_mem_req = 0; e_vack = 0; e_cack = 0; e_dack = 0;
        if (busy) begin
            if (cur.age >= 1 && mem_ack) begin
                busy = 0;
                case (cur.owner)
                    1: begin e_vq = mem_q; e_vack = 1; end
                    2: begin e_cq = mem_q; e_cack = 1; end
                    default: begin e_dq = mem_q; e_dack = 1; end
                endcase
            end else if (cur.age >= 1 && m_ph % 8 == 7) begin
                busy = 0; e_err = 1;
            end else cur.age++;
        end else if (m_ph % 8 == 0) begin
            w = pick();
            if (w != 0) begin
                cur.owner = w; cur.age = 0;
                case (w)
                    1: begin cur.we = 0; cur.a = vid_a; cur.d = 0; end
                    2: begin cur.we = cpu_we; cur.a = cpu_a; cur.d = cpu_d; end
                    default: begin cur.we = dma_we; cur.a = dma_a; cur.d = dma_d; end
                endcase
                if (m_ph == 8) begin
                    if (w == 3) m_dma_wait = 0;
                    else if (dma_req) m_dma_wait++;
                end
                busy = 1; e_mem_req = 1;
                e_mem_we = cur.we; e_mem_a = cur.a; e_mem_d = cur.d;
            end
        end
        m_ph = sync ? 0 : (m_ph + 1) % 16;
    endtask

    task automatic check_cycle();
        chk("mem_req", mem_req, e_mem_req);
        if (e_mem_req) begin
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_a", mem_a, e_mem_a);
            chk("mem_d", mem_d, e_mem_d);
        end
        chk("vid_ack", vid_ack, e_vack);
        chk("cpu_ack", cpu_ack, e_cack);
        chk("dma_ack", dma_ack, e_dack);
        chk("vid_q", vid_q, e_vq);
        chk("cpu_q", cpu_q, e_cq);
        chk("dma_q", dma_q, e_dq);
        chk("err", err, e_err);
    endtask

    task automatic req_step(input bit en, input bit acked, input bit granted, inout logic req,
                            inout logic we, inout logic [23:0] a, inout logic [7:0] d);
        if (!en) req = 0;
        else if (acked) begin
            if (fixed || $urandom_range(0, 1) == 1) begin
                req = 1;
                if (!fixed) begin we = 1'($urandom); a = 24'($urandom); d = 8'($urandom); end
            end else req = 0;
        end else if (!req) begin
            if (fixed || $urandom_range(0, 3) == 0) begin
                req = 1;
                if (!fixed) begin we = 1'($urandom); a = 24'($urandom); d = 8'($urandom); end
            end
        end else if (!fixed && !granted && $urandom_range(0, 39) == 0) req = 0;
    endtask

    task automatic drive();
        sync = aligned && (m_ph == 15);
        if (rnd_sync && $urandom_range(0, 63) == 0) sync = 1;
        if (sync_once >= 0 && m_ph == sync_once && busy) begin sync = 1; sync_once = -1; end
        mem_ack = 0;
        if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) begin mem_ack = 1; mem_q = rnd_q ? 8'($urandom) : fix_q; end
        end
        if (e_mem_req && delay != 0) ack_cd = (delay < 0) ? int'($urandom_range(1, 8)) : delay;
        else if (!mem_ack && spurious && !busy && $urandom_range(0, 19) == 0) begin
            mem_ack = 1; mem_q = 8'($urandom);
        end
        req_step(en_v, e_vack, busy && cur.owner == 1, vid_req, dummy_we, vid_a, dummy_d);
        req_step(en_c, e_cack, busy && cur.owner == 2, cpu_req, cpu_we, cpu_a, cpu_d);
        req_step(en_d, e_dack, busy && cur.owner == 3, dma_req, dma_we, dma_a, dma_d);
    endtask

    task automatic cycle();
        @(posedge clock);
        m_edge();
        #1;
        check_cycle();
        drive();
    endtask

    task automatic do_reset();
        power = 0; ack_cd = 0; mem_ack = 0; sync = 0; sync_once = -1;
        vid_req = 0; cpu_req = 0; dma_req = 0;
        #2;
        model_reset();
        chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);     chk("rst_mem_d", mem_d, 0);
        chk("rst_vid_q", vid_q, 0);     chk("rst_vid_ack", vid_ack, 0);
        chk("rst_cpu_q", cpu_q, 0);     chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_q", dma_q, 0);     chk("rst_dma_ack", dma_ack, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clock);
        #1;
        power = 1;
        drive();
    endtask

    initial begin
        model_reset();
        #1;
        // Video only: ack 2 clocks after mem_req with 0xA5.
        en_v = 1; en_c = 0; en_d = 0; fixed = 1; vid_a = 24'h004000;
        delay = 2; rnd_q = 0; fix_q = 8'hA5; spurious = 0; rnd_sync = 0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (m_ph == 1) chk("vid_mem_req_ph1", mem_req, 1);
            if (m_ph == 4) chk("vid_ack_ph4", vid_ack, 1);
        end
        chk("vid_q_a5", vid_q, 8'hA5);

        // CPU write vs DMA: DMA owns the video slot, CPU wins 3 shared slots then DMA once.
        en_v = 0; en_c = 1; en_d = 1; delay = 1; rnd_q = 1;
        cpu_we = 1; cpu_a = 24'h100000; cpu_d = 8'h3C;
        dma_we = 1; dma_a = 24'h200000; dma_d = 8'hC3;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (m_ph == 1) chk("cd_vid_slot_dma", mem_a, 24'h200000);
            if (m_ph == 9) chk("cd_shr_owner", mem_a, (i / 16 == 3) ? 24'h200000 : 24'h100000);
        end

        // Timeout on a CPU read: err set, no ack, regranted next shared slot.
        en_d = 0; cpu_we = 0; delay = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i >= 16 && m_ph == 0) chk("to_err", err, 1);
            if (m_ph == 9) chk("to_regrant", mem_req, 1);
        end

        // Ack coincident with the video timeout phase.
        en_c = 0; en_v = 1; delay = 6; rnd_q = 0; fix_q = 8'h5A;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (m_ph == 8) chk("coinc_vid_ack", vid_ack, 1);
        end
        chk("coinc_err", err, 0);

        // Reset while waiting, then a stale mem_ack after release.
        delay = 0;
        do_reset();
        for (int n = 0; n < 40 && !e_mem_req; n++) cycle();
        chk("rw_mem_req_seen", mem_req, 1);
        cycle();
        do_reset();
        mem_ack = 1; mem_q = 8'hFF; vid_req = 1;
        cycle();
        chk("rw_ph_restart", mem_req, 1);
        for (int i = 0; i < 6; i++) cycle();
        chk("rw_vid_q", vid_q, 0);

        // sync at ph 5 during WAIT: timeout against the realigned phase, then completion.
        do_reset();
        sync_once = 5;
        for (int i = 0; i < 32; i++) cycle();
        chk("sync_to_err", err, 1);
        delay = 5;
        do_reset();
        sync_once = 5;
        for (int i = 0; i < 32; i++) cycle();
        chk("sync_ack_err", err, 0);
        chk("sync_ack_q", vid_q, 8'h5A);

        // Random traffic on all requesters.
        en_v = 1; en_c = 1; en_d = 1; fixed = 0; delay = -1;
        spurious = 1; rnd_q = 1; rnd_sync = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
